// File: rtl/router_vc_rr_alloc.sv
// router_vc_rr_alloc: two-VC round-robin ownership allocator with per-VC credit tracking.
// Optional build macro VCARB_FIXED_PRIO_EN pins the search pointer at 0 (fixed priority).
`default_nettype none

module router_vc_rr_lane #(
   parameter int NO_OF_REQS = 15,
   parameter int CREDITS    = 4,
   parameter int CW         = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NO_OF_REQS-1:0] req,
   input  logic                  flit_sent,
   input  logic                  tail,
   input  logic                  credit_in,
   output logic [NO_OF_REQS-1:0] grant,
   output logic                  usage,
   output logic                  credit_avail
);

   localparam int PW = (NO_OF_REQS > 1) ? $clog2(NO_OF_REQS) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic [NO_OF_REQS-1:0]   grant_q, grant_nxt;
   logic [PW-1:0]           ptr, ptr_nxt;
   logic [CW-1:0]           count, count_nxt;
   logic [PW-1:0]           win;
   logic [PW-1:0]           idx;
   logic                    found;
   logic                    accept;
   int                      pos;

   // Cyclic search starting at ptr; the first requester found wins.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NO_OF_REQS; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NO_OF_REQS) pos = pos - NO_OF_REQS;
         idx = PW'(pos);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign accept = flit_sent && (state == BUSY) && (count != '0);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               grant_nxt = {{(NO_OF_REQS-1){1'b0}}, 1'b1} << win;
`ifdef VCARB_FIXED_PRIO_EN
               ptr_nxt   = '0;
`else
               ptr_nxt   = (win == PW'(NO_OF_REQS-1)) ? '0 : win + PW'(1);
`endif
            end
         end
         BUSY: begin
            if (accept && tail) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // A simultaneous accepted flit and returned credit cancel out.
   always_comb begin
      count_nxt = count;
      if (accept && !credit_in)
         count_nxt = count - CW'(1);
      else if (!accept && credit_in && (count < CW'(CREDITS)))
         count_nxt = count + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         grant_q <= '0;
         ptr     <= '0;
         count   <= CW'(CREDITS);
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         ptr     <= ptr_nxt;
         count   <= count_nxt;
      end
   end

   assign grant        = grant_q;
   assign usage        = (state == BUSY);
   assign credit_avail = (count != '0);

endmodule

module router_vc_rr_alloc #(
   parameter int NO_OF_REQS = 15,
   parameter int CREDITS    = 4,
   parameter int CW         = 3
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [NO_OF_REQS-1:0] Port_vc0_arb_req,
   input  logic [NO_OF_REQS-1:0] Port_vc1_arb_req,
   input  logic                  Port_vc0_flit_sent,
   input  logic                  Port_vc1_flit_sent,
   input  logic                  Port_vc0_tail,
   input  logic                  Port_vc1_tail,
   input  logic                  Port_vc0_credit_in,
   input  logic                  Port_vc1_credit_in,
   output logic [NO_OF_REQS-1:0] Port_vc0_arb_grant,
   output logic [NO_OF_REQS-1:0] Port_vc1_arb_grant,
   output logic                  Port_vc0_usage,
   output logic                  Port_vc1_usage,
   output logic                  Port_vc0_credit_avail,
   output logic                  Port_vc1_credit_avail
);

   router_vc_rr_lane #(
      .NO_OF_REQS (NO_OF_REQS),
      .CREDITS    (CREDITS),
      .CW         (CW)
   ) u_vc0 (
      .clk          (Clk),
      .rst_n        (Rst),
      .req          (Port_vc0_arb_req),
      .flit_sent    (Port_vc0_flit_sent),
      .tail         (Port_vc0_tail),
      .credit_in    (Port_vc0_credit_in),
      .grant        (Port_vc0_arb_grant),
      .usage        (Port_vc0_usage),
      .credit_avail (Port_vc0_credit_avail)
   );

   router_vc_rr_lane #(
      .NO_OF_REQS (NO_OF_REQS),
      .CREDITS    (CREDITS),
      .CW         (CW)
   ) u_vc1 (
      .clk          (Clk),
      .rst_n        (Rst),
      .req          (Port_vc1_arb_req),
      .flit_sent    (Port_vc1_flit_sent),
      .tail         (Port_vc1_tail),
      .credit_in    (Port_vc1_credit_in),
      .grant        (Port_vc1_arb_grant),
      .usage        (Port_vc1_usage),
      .credit_avail (Port_vc1_credit_avail)
   );

endmodule

`default_nettype wire

// File: tb/tb_router_vc_rr_alloc.sv
// Self-checking bench for router_vc_rr_alloc: vector table, directed corner sequences, random vs. model.
`default_nettype none

module tb_router_vc_rr_alloc;

   localparam int N  = 15;
   localparam int CR = 4;

   logic          clk = 1'b0;
   logic          rst_b;
   logic [N-1:0]  req0, req1;
   logic          fs0, fs1, t0, t1, c0, c1;
   logic [N-1:0]  grant0, grant1;
   logic          usage0, usage1, avail0, avail1;

   int errors = 0;
   int checks = 0;

   int m_owner [2];
   int m_ptr   [2];
   int m_cred  [2];

   always #5 clk = ~clk;

   router_vc_rr_alloc #(.NO_OF_REQS(N), .CREDITS(CR), .CW(3)) dut (
      .Clk                   (clk),
      .Rst                   (rst_b),
      .Port_vc0_arb_req      (req0),
      .Port_vc1_arb_req      (req1),
      .Port_vc0_flit_sent    (fs0),
      .Port_vc1_flit_sent    (fs1),
      .Port_vc0_tail         (t0),
      .Port_vc1_tail         (t1),
      .Port_vc0_credit_in    (c0),
      .Port_vc1_credit_in    (c1),
      .Port_vc0_arb_grant    (grant0),
      .Port_vc1_arb_grant    (grant1),
      .Port_vc0_usage        (usage0),
      .Port_vc1_usage        (usage1),
      .Port_vc0_credit_avail (avail0),
      .Port_vc1_credit_avail (avail1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: owner index (-1 = free), search pointer and credit count per VC.
   task automatic model_step(input int v, input logic r, input logic [N-1:0] q,
                             input logic f, input logic t, input logic c);
      int     w;
      int     acc;
      int     nc;
      if (!r) begin
         m_owner[v] = -1;
         m_ptr[v]   = 0;
         m_cred[v]  = CR;
         return;
      end
      acc = (f && m_owner[v] >= 0 && m_cred[v] > 0) ? 1 : 0;
      if (m_owner[v] < 0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            if (w < 0 && q[(m_ptr[v] + k) % N]) w = (m_ptr[v] + k) % N;
         end
         if (w >= 0) begin
            m_owner[v] = w;
`ifdef VCARB_FIXED_PRIO_EN
            m_ptr[v]   = 0;
`else
            m_ptr[v]   = (w + 1) % N;
`endif
         end
      end else if (acc == 1 && t) begin
         m_owner[v] = -1;
      end
      nc = m_cred[v] - acc + (c ? 1 : 0);
      m_cred[v] = (nc > CR) ? CR : nc;
   endtask

   function automatic int exp_grant(input int v);
      return (m_owner[v] < 0) ? 0 : (1 << m_owner[v]);
   endfunction

   task automatic cyc(input logic r,
                      input logic [N-1:0] q0, input logic f0, input logic tl0, input logic cc0,
                      input logic [N-1:0] q1, input logic f1, input logic tl1, input logic cc1);
      rst_b = r;
      req0 = q0; fs0 = f0; t0 = tl0; c0 = cc0;
      req1 = q1; fs1 = f1; t1 = tl1; c1 = cc1;
      @(posedge clk);
      #1;
      model_step(0, r, q0, f0, tl0, cc0);
      model_step(1, r, q1, f1, tl1, cc1);
      chk("model_grant0", int'(grant0), exp_grant(0));
      chk("model_grant1", int'(grant1), exp_grant(1));
      chk("model_usage0", int'(usage0), (m_owner[0] >= 0) ? 1 : 0);
      chk("model_usage1", int'(usage1), (m_owner[1] >= 0) ? 1 : 0);
      chk("model_avail0", int'(avail0), (m_cred[0] > 0) ? 1 : 0);
      chk("model_avail1", int'(avail1), (m_cred[1] > 0) ? 1 : 0);
      chk("onehot0_grant", ($onehot0(grant0) && $onehot0(grant1)) ? 1 : 0, 1);
   endtask

   task automatic cyc0(input logic r, input logic [N-1:0] q, input logic f,
                       input logic tl, input logic cc);
      cyc(r, q, f, tl, cc, q, f, tl, cc);
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic         fs;
      logic         tail;
      logic         cin;
      logic [N-1:0] g_rr;
      logic [N-1:0] g_fp;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [N-1:0] eg;

      tbl[0]  = '{1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000};
      tbl[1]  = '{1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000};
      tbl[2]  = '{1'b1, 15'h7FFF, 1'b0, 1'b0, 1'b0, 15'h0001, 15'h0001};
      tbl[3]  = '{1'b1, 15'h0005, 1'b1, 1'b1, 1'b0, 15'h0000, 15'h0000};
      tbl[4]  = '{1'b1, 15'h0005, 1'b0, 1'b0, 1'b1, 15'h0004, 15'h0001};
      tbl[5]  = '{1'b1, 15'h0005, 1'b1, 1'b1, 1'b0, 15'h0000, 15'h0000};
      tbl[6]  = '{1'b1, 15'h0005, 1'b0, 1'b0, 1'b1, 15'h0001, 15'h0001};
      tbl[7]  = '{1'b1, 15'h0005, 1'b1, 1'b1, 1'b0, 15'h0000, 15'h0000};
      tbl[8]  = '{1'b1, 15'h2000, 1'b0, 1'b0, 1'b0, 15'h2000, 15'h2000};
      tbl[9]  = '{1'b1, 15'h0000, 1'b1, 1'b1, 1'b0, 15'h0000, 15'h0000};
      tbl[10] = '{1'b1, 15'h4001, 1'b0, 1'b0, 1'b1, 15'h4000, 15'h0001};
      tbl[11] = '{1'b1, 15'h4001, 1'b1, 1'b1, 1'b0, 15'h0000, 15'h0000};
      tbl[12] = '{1'b1, 15'h4001, 1'b0, 1'b0, 1'b1, 15'h0001, 15'h0001};
      tbl[13] = '{1'b1, 15'h0000, 1'b1, 1'b1, 1'b1, 15'h0000, 15'h0000};

      m_owner = '{-1, -1};
      m_ptr   = '{0, 0};
      m_cred  = '{CR, CR};
      rst_b = 1'b0;
      req0 = '0; req1 = '0;
      fs0 = 1'b0; fs1 = 1'b0; t0 = 1'b0; t1 = 1'b0; c0 = 1'b0; c1 = 1'b0;

      // Reset, round-robin alternation and pointer wrap, both VCs driven alike.
      for (int i = 0; i < 14; i++) begin
         cyc0(tbl[i].rst, tbl[i].req, tbl[i].fs, tbl[i].tail, tbl[i].cin);
`ifdef VCARB_FIXED_PRIO_EN
         eg = tbl[i].g_fp;
`else
         eg = tbl[i].g_rr;
`endif
         chk($sformatf("tbl%0d_grant0", i), int'(grant0), int'(eg));
         chk($sformatf("tbl%0d_grant1", i), int'(grant1), int'(eg));
         chk($sformatf("tbl%0d_usage0", i), int'(usage0), (eg != '0) ? 1 : 0);
         chk($sformatf("tbl%0d_avail0", i), int'(avail0), 1);
      end

      // Hold: owner 3 drops its request, requester 7 waits.
      cyc0(1'b1, 15'h0008, 1'b0, 1'b0, 1'b0);
      chk("hold_grab", int'(grant0), 32'h0008);
      for (int i = 0; i < 10; i++) begin
         cyc0(1'b1, 15'h0080, 1'b0, 1'b0, 1'b0);
         chk($sformatf("hold_cyc%0d", i), int'(grant0), 32'h0008);
      end
      cyc0(1'b1, 15'h0080, 1'b1, 1'b1, 1'b0);
      chk("hold_release", int'(grant0), 0);
      cyc0(1'b1, 15'h0080, 1'b0, 1'b0, 1'b0);
      chk("hold_next", int'(grant0), 32'h0080);
      cyc0(1'b1, 15'h0000, 1'b1, 1'b1, 1'b1);
      chk("hold_done", int'(grant1), 0);

      // Credit exhaustion blocks the tail until a credit returns.
      cyc0(1'b0, 15'h0000, 1'b0, 1'b0, 1'b0);
      cyc0(1'b1, 15'h0001, 1'b0, 1'b0, 1'b0);
      chk("cred_grant", int'(grant0), 32'h0001);
      for (int i = 0; i < 4; i++) begin
         cyc0(1'b1, 15'h0001, 1'b1, 1'b0, 1'b0);
         chk($sformatf("cred_avail%0d", i), int'(avail0), (i < 3) ? 1 : 0);
      end
      cyc0(1'b1, 15'h0001, 1'b1, 1'b1, 1'b0);
      chk("cred_tail_ignored", int'(grant0), 32'h0001);
      chk("cred_still_zero", int'(avail0), 0);
      cyc0(1'b1, 15'h0001, 1'b0, 1'b0, 1'b1);
      chk("cred_returned", int'(avail0), 1);
      cyc0(1'b1, 15'h0000, 1'b1, 1'b1, 1'b0);
      chk("cred_release", int'(grant0), 0);
      chk("cred_usage", int'(usage0), 0);
      for (int i = 0; i < 6; i++) cyc0(1'b1, 15'h0000, 1'b0, 1'b0, 1'b1);

      // Random traffic on both VCs independently.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 63) != 0),
             15'($urandom) & 15'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             15'($urandom) & 15'($urandom) & 15'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
